// File: rtl/rq_arb_pkg.sv
// rq_arb_pkg: shared types, constants and round-robin pick function for rq_stream_arbiter
package rq_arb_pkg;

    localparam int TUSER_W   = 4;
    localparam int MAX_PORTS = 8;

    typedef enum logic [0:0] {ST_IDLE, ST_LOCK} state_t;

    typedef struct packed {
        logic       any;
        logic [2:0] idx;
    } pick_t;

    // First asserted request at or above ptr, wrapping at n; lowest offset wins.
    function automatic pick_t rr_pick(input logic [MAX_PORTS-1:0] req, input logic [2:0] ptr, input int n);
        pick_t p;
        int j;
        p = '{any: 1'b0, idx: 3'd0};
        for (int i = MAX_PORTS - 1; i >= 0; i--) begin
            if (i < n) begin
                j = int'(ptr) + i;
                if (j >= n) j = j - n;
                if (req[3'(j)]) begin
                    p.any = 1'b1;
                    p.idx = 3'(j);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rq_arb_skid.sv
// rq_arb_skid: 2-entry AXIS skid buffer with registered outputs and registered upstream ready
module rq_arb_skid #(
    parameter int W = 293
) (
    input  logic         user_clk,
    input  logic         user_reset_n,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready
);

    logic         skid_valid;
    logic [W-1:0] skid_data;

    // Output register fed directly when it can move, otherwise park the beat in the skid slot.
    // Ready is held low during reset and rises on the first clock after release.
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            m_valid    <= 1'b0;
            skid_valid <= 1'b0;
            s_ready    <= 1'b0;
            m_data     <= '0;
            skid_data  <= '0;
        end else if (!s_ready && !skid_valid) begin
            s_ready <= 1'b1;
        end else if (s_ready) begin
            if (!m_valid || m_ready) begin
                m_valid <= s_valid;
                if (s_valid) m_data <= s_data;
            end else if (s_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= s_data;
                s_ready    <= 1'b0;
            end
        end else if (m_ready) begin
            m_data     <= skid_data;
            skid_valid <= 1'b0;
            s_ready    <= 1'b1;
        end
    end

endmodule

// File: rtl/rq_stream_arbiter.sv
// rq_stream_arbiter: packet-atomic round-robin arbiter sharing the 256-bit RQ stream.
// Optional: define RQ_ARB_PORT0_PRIORITY_EN to give port 0 absolute priority when idle.
module rq_stream_arbiter
    import rq_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 3,
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int IDX_W      = $clog2(NUM_PORTS)
) (
    input  logic                            user_clk,
    input  logic                            user_reset_n,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_rq_tdata,
    input  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_axis_rq_tkeep,
    input  logic [NUM_PORTS-1:0]            s_axis_rq_tlast,
    input  logic [NUM_PORTS*TUSER_W-1:0]    s_axis_rq_tuser,
    input  logic [NUM_PORTS-1:0]            s_axis_rq_tvalid,
    output logic [NUM_PORTS-1:0]            s_axis_rq_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_rq_tdata,
    output logic [KEEP_WIDTH-1:0]           m_axis_rq_tkeep,
    output logic                            m_axis_rq_tlast,
    output logic [TUSER_W-1:0]              m_axis_rq_tuser,
    output logic                            m_axis_rq_tvalid,
    input  logic                            m_axis_rq_tready,
    output logic [IDX_W-1:0]                grant_idx,
    output logic                            busy
);

    localparam int PW = DATA_WIDTH + KEEP_WIDTH + 1 + TUSER_W;

    state_t                 state;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       sel;
    logic [IDX_W-1:0]       sel_next;
    logic [MAX_PORTS-1:0]   req_pad;
    pick_t                  pick;
    logic                   sel_valid;
    logic                   sel_last;
    logic                   accept;
    logic                   adv;
    logic                   skid_ready;
    logic [PW-1:0]          payload [NUM_PORTS];
    logic [PW-1:0]          skid_out;

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_pack
        assign payload[k] = {s_axis_rq_tdata[k*DATA_WIDTH +: DATA_WIDTH],
                             s_axis_rq_tkeep[k*KEEP_WIDTH +: KEEP_WIDTH],
                             s_axis_rq_tlast[k],
                             s_axis_rq_tuser[k*TUSER_W +: TUSER_W]};
    end

    // Round-robin winner among the currently valid ports, starting at rr_ptr.
    always_comb begin
        req_pad                  = '0;
        req_pad[NUM_PORTS-1:0]   = s_axis_rq_tvalid;
        pick                     = rr_pick(req_pad, 3'(rr_ptr), NUM_PORTS);
    end

`ifdef RQ_ARB_PORT0_PRIORITY_EN
    assign win_idx = s_axis_rq_tvalid[0] ? '0 : IDX_W'(pick.idx);
    assign adv     = sel != '0;
`else
    assign win_idx = IDX_W'(pick.idx);
    assign adv     = 1'b1;
`endif

    assign busy      = state == ST_LOCK;
    assign sel       = busy ? grant_idx : win_idx;
    assign sel_valid = busy ? s_axis_rq_tvalid[grant_idx] : pick.any;
    assign sel_last  = s_axis_rq_tlast[sel];
    assign accept    = sel_valid && skid_ready;
    assign sel_next  = (sel == IDX_W'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;

    // Only the selected port sees buffer ready; nobody does while idle with no requests.
    always_comb begin
        s_axis_rq_tready = '0;
        for (int k = 0; k < NUM_PORTS; k++)
            s_axis_rq_tready[k] = skid_ready && (busy || pick.any) && (sel == IDX_W'(k));
    end

    // Lock the stream on a non-final first beat; release and advance the pointer on tlast.
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
        end else if (accept) begin
            grant_idx <= sel;
            state     <= sel_last ? ST_IDLE : ST_LOCK;
            if (sel_last && adv) rr_ptr <= sel_next;
        end
    end

    rq_arb_skid #(
        .W (PW)
    ) u_skid (
        .user_clk     (user_clk),
        .user_reset_n (user_reset_n),
        .s_data       (payload[sel]),
        .s_valid      (sel_valid),
        .s_ready      (skid_ready),
        .m_data       (skid_out),
        .m_valid      (m_axis_rq_tvalid),
        .m_ready      (m_axis_rq_tready)
    );

    assign {m_axis_rq_tdata, m_axis_rq_tkeep, m_axis_rq_tlast, m_axis_rq_tuser} = skid_out;

endmodule

// File: tb/tb_rq_stream_arbiter.sv
// tb_rq_stream_arbiter: randomized bench against a packet/occupancy-level reference model
module tb_rq_stream_arbiter;

    localparam int N  = 3;
    localparam int DW = 256;
    localparam int KW = DW / 8;
    localparam int IW = 2;
    localparam int PW = DW + KW + 1 + 4;

    logic            user_clk     = 1'b0;
    logic            user_reset_n = 1'b1;
    logic [N*DW-1:0] s_tdata      = '0;
    logic [N*KW-1:0] s_tkeep      = '0;
    logic [N-1:0]    s_tlast      = '0;
    logic [N*4-1:0]  s_tuser      = '0;
    logic [N-1:0]    s_tvalid     = '0;
    logic [N-1:0]    s_tready;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tlast;
    logic [3:0]      m_tuser;
    logic            m_tvalid;
    logic            m_tready     = 1'b0;
    logic [IW-1:0]   grant_idx;
    logic            busy;

    always #5 user_clk = ~user_clk;

    rq_stream_arbiter #(
        .NUM_PORTS  (N),
        .DATA_WIDTH (DW)
    ) dut (
        .user_clk         (user_clk),
        .user_reset_n     (user_reset_n),
        .s_axis_rq_tdata  (s_tdata),
        .s_axis_rq_tkeep  (s_tkeep),
        .s_axis_rq_tlast  (s_tlast),
        .s_axis_rq_tuser  (s_tuser),
        .s_axis_rq_tvalid (s_tvalid),
        .s_axis_rq_tready (s_tready),
        .m_axis_rq_tdata  (m_tdata),
        .m_axis_rq_tkeep  (m_tkeep),
        .m_axis_rq_tlast  (m_tlast),
        .m_axis_rq_tuser  (m_tuser),
        .m_axis_rq_tvalid (m_tvalid),
        .m_axis_rq_tready (m_tready),
        .grant_idx        (grant_idx),
        .busy             (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model: beats accepted but not yet emitted, lock owner, round-robin pointer
    logic [PW-1:0] q[$];
    bit            mlock = 1'b0;
    int            mgrant = 0;
    int            mptr = 0;

    // source state
    int blen[N]  = '{2, 2, 2};
    int bidx[N]  = '{0, 0, 0};
    int vprob[N] = '{0, 0, 0};
    bit fired[N] = '{0, 0, 0};
    int lo_len = 1;
    int hi_len = 1;
    int rprob = 100;

    function automatic logic [PW-1:0] port_beat(input int k);
        return {s_tdata[k*DW +: DW], s_tkeep[k*KW +: KW], s_tlast[IW'(k)], s_tuser[k*4 +: 4]};
    endfunction

    task automatic new_beat(input int k);
        for (int w = 0; w < DW / 32; w++) s_tdata[k*DW + w*32 +: 32] = $urandom;
        s_tkeep[k*KW +: KW] = $urandom;
        s_tuser[k*4 +: 4]   = 4'($urandom);
        s_tlast[IW'(k)]     = bidx[k] == blen[k] - 1;
    endtask

    // Advance sources after handshakes; never withdraw an unaccepted beat.
    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (fired[k]) begin
                bidx[k]++;
                if (bidx[k] == blen[k]) begin
                    bidx[k] = 0;
                    blen[k] = $urandom_range(hi_len, lo_len);
                end
                s_tvalid[IW'(k)] = 1'b0;
            end
            if (!s_tvalid[IW'(k)] && $urandom_range(99, 0) < vprob[k]) begin
                s_tvalid[IW'(k)] = 1'b1;
                new_beat(k);
            end
        end
        m_tready = $urandom_range(99, 0) < rprob;
    endtask

    // Compare outputs to the model, then apply the handshakes due at the next edge.
    task automatic sample();
        logic [N-1:0] er;
        int           w;
        bit           any;
        chk("m_tvalid", PW'(m_tvalid), PW'(q.size() > 0));
        if (m_tvalid && q.size() > 0) chk("m_beat", {m_tdata, m_tkeep, m_tlast, m_tuser}, q[0]);
        chk("busy", PW'(busy), PW'(mlock));
        if (mlock) chk("grant_idx", PW'(grant_idx), PW'(mgrant));
        any = 1'b0;
        w   = 0;
        if (mlock) begin
            any = 1'b1;
            w   = mgrant;
        end else begin
            for (int i = N - 1; i >= 0; i--)
                if (s_tvalid[IW'((mptr + i) % N)]) begin
                    any = 1'b1;
                    w   = (mptr + i) % N;
                end
`ifdef RQ_ARB_PORT0_PRIORITY_EN
            if (s_tvalid[0]) w = 0;
`endif
        end
        er = '0;
        if (any && q.size() < 2) er[IW'(w)] = 1'b1;
        chk("s_tready", PW'(s_tready), PW'(er));
        if (m_tvalid && m_tready && q.size() > 0) void'(q.pop_front());
        for (int k = 0; k < N; k++) begin
            fired[k] = s_tvalid[IW'(k)] && s_tready[IW'(k)];
            if (fired[k]) begin
                q.push_back(port_beat(k));
                if (s_tlast[IW'(k)]) begin
                    mlock = 1'b0;
`ifdef RQ_ARB_PORT0_PRIORITY_EN
                    if (k != 0) mptr = (k + 1) % N;
`else
                    mptr = (k + 1) % N;
`endif
                end else begin
                    mlock  = 1'b1;
                    mgrant = k;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge user_clk);
        #1;
        drive();
        @(negedge user_clk);
        sample();
    endtask

    task automatic run(input int n, input int v0, input int v1, input int v2, input int lo, input int hi, input int rp);
        vprob[0] = v0;
        vprob[1] = v1;
        vprob[2] = v2;
        lo_len   = lo;
        hi_len   = hi;
        rprob    = rp;
        repeat (n) cycle();
    endtask

    // Asynchronous reset with valids still asserted; partial packets are dropped.
    task automatic do_reset();
        user_reset_n = 1'b0;
        #1;
        chk("rst_m_tvalid", PW'(m_tvalid), PW'(0));
        chk("rst_busy", PW'(busy), PW'(0));
        chk("rst_s_tready", PW'(s_tready), PW'(0));
        chk("rst_grant_idx", PW'(grant_idx), PW'(0));
        s_tvalid = '0;
        for (int k = 0; k < N; k++) begin
            fired[k] = 1'b0;
            bidx[k]  = 0;
        end
        q.delete();
        mlock  = 1'b0;
        mptr   = 0;
        mgrant = 0;
        repeat (2) @(posedge user_clk);
        #1;
        user_reset_n = 1'b1;
        @(negedge user_clk);
        sample();
    endtask

    initial begin
        bit found;
        #2;
        do_reset();
        // single requester, 3-beat packets, no backpressure
        run(20, 0, 100, 0, 3, 3, 100);
        // all requesters continuously busy with 2-beat packets
        run(40, 100, 100, 100, 2, 2, 100);
        // port 0 stutters mid-packet while the others wait
        run(60, 30, 100, 100, 3, 5, 100);
        // random traffic with heavy backpressure
        run(400, 60, 60, 60, 1, 5, 50);
        run(100, 100, 100, 100, 1, 1, 40);
        // drain, then reset on beat 2 of a 4-beat port-0 packet
        run(10, 0, 0, 0, 4, 4, 100);
        vprob[0] = 100;
        found    = 1'b0;
        for (int t = 0; t < 60 && !found; t++) begin
            cycle();
            found = blen[0] == 4 && bidx[0] == 1 && s_tvalid[0];
        end
        chk("rst_wait", PW'(found), PW'(1));
        do_reset();
        // clean grant for port 2 after reset
        run(20, 0, 0, 100, 2, 2, 100);
        run(200, 70, 70, 70, 1, 4, 70);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rq_stream_arbiter.md
Name: rq_stream_arbiter

Overview:
- Packet-atomic round-robin arbiter that shares the single 256-bit requester-request (RQ) stream between NUM_PORTS internal requesters, e.g. the DMA reader, DMA writer and MSI generator.
- Sits directly upstream of the RQ width/format adapter; its output uses the same 256-bit TLP-formatted stream (tdata/tkeep/tlast/4-bit tuser).
- Once a requester is granted, it owns the stream until its tlast beat is accepted, so TLPs never interleave.

Parameters:
NUM_PORTS, 3, number of requester ports (2..8)
DATA_WIDTH, 256, stream data width in bits
KEEP_WIDTH, DATA_WIDTH/8, byte-enable width
IDX_W, $clog2(NUM_PORTS), grant index width

Ports:
user_clk  input  1  stream clock
user_reset_n  input  1  asynchronous, active-low reset
s_axis_rq_tdata  input  NUM_PORTS*DATA_WIDTH  per-port data, port k at slice k
s_axis_rq_tkeep  input  NUM_PORTS*KEEP_WIDTH  per-port byte enables
s_axis_rq_tlast  input  NUM_PORTS  per-port end of packet
s_axis_rq_tuser  input  NUM_PORTS*4  per-port tuser {disc,?,ep,td}, passed through unchanged
s_axis_rq_tvalid  input  NUM_PORTS  per-port valid
s_axis_rq_tready  output  NUM_PORTS  per-port ready
m_axis_rq_tdata  output  DATA_WIDTH  arbitrated data
m_axis_rq_tkeep  output  KEEP_WIDTH  arbitrated byte enables
m_axis_rq_tlast  output  1  arbitrated end of packet
m_axis_rq_tuser  output  4  arbitrated tuser
m_axis_rq_tvalid  output  1  arbitrated valid
m_axis_rq_tready  input  1  downstream ready (adapter)
grant_idx  output  IDX_W  port currently owning the stream (valid while busy=1)
busy  output  1  FSM in LOCK state

Behaviour:
- Reset: async assert on user_reset_n=0, synchronous release. Effects:
  - FSM = IDLE, rr_ptr = 0, grant_idx = 0, busy = 0.
  - m_axis_rq_tvalid = 0, all s_axis_rq_tready = 0, skid buffer emptied.
  - Reset mid-packet discards the partial packet silently; no tlast is generated.
- FSM has two states.
- IDLE:
  - Winner = first asserted tvalid, searching from rr_ptr upward with wrap.
  - If any tvalid is asserted, the winner is granted combinationally in the same cycle. Its tready = skid-buffer ready, so the first beat can transfer in the same cycle.
  - If that beat is accepted and tlast=0 → LOCK. If it is a single-beat packet (tlast=1) → stay IDLE and set rr_ptr = winner+1 (mod NUM_PORTS).
  - If the beat is not accepted, the FSM stays IDLE and the grant may be re-decided next cycle.
- LOCK:
  - Only grant_idx sees tready; every other port has tready = 0.
  - When the granted port de-asserts tvalid mid-packet, hold the lock and insert no foreign beats.
  - On an accepted beat with tlast=1 → IDLE, rr_ptr = grant_idx+1 (mod NUM_PORTS).
- Throughput: back-to-back packets with zero idle cycles; the IDLE grant is combinational.
- Output stage: 2-entry skid buffer (sub-module).
  - Latency is exactly 1 cycle from input acceptance to m_axis_rq_tvalid.
  - Sustains 1 beat/cycle under continuous m_axis_rq_tready.
  - Upstream ready = buffer not full. All m_axis_* outputs are registered.
- Ordering: beats of one packet leave in input order. Packets leave in grant order.
- Downstream AXIS rule: once m_axis_rq_tvalid is asserted, it and tdata/tkeep/tlast/tuser hold stable until tready=1.
- Fairness: with all ports continuously requesting, grant order is 0,1,2,0,1,2…; no port waits more than NUM_PORTS-1 packets.
- Simultaneous tlast acceptance and new requests: the new grant is decided in the next cycle (IDLE), with no bubble when the buffer has room.
- Non-power-of-2 NUM_PORTS: rr_ptr wraps at NUM_PORTS-1 → 0. Indices ≥ NUM_PORTS are never granted.

Optional Feature:
RQ_ARB_PORT0_PRIORITY_EN
- Defined: in IDLE, port 0 wins whenever its tvalid=1, regardless of rr_ptr. This is for the MSI/interrupt requester. rr_ptr is still updated only by grants to ports 1..NUM_PORTS-1, so those ports round-robin among themselves. An in-progress lock is never pre-empted.
- Undefined: pure round-robin as above.

Decomposition:
- Package rq_arb_pkg holds:
  - FSM state enum {ST_IDLE, ST_LOCK}.
  - TUSER_W = 4.
  - Function rr_pick(req, ptr) returning the winner index and an any-request flag.
- Sub-module rq_arb_skid: generic 2-entry AXIS skid buffer, parameterised on payload width (DATA_WIDTH+KEEP_WIDTH+1+4). Same clock and reset ports.

Test Plan:
- Single port: port 1 sends a 3-beat packet, m_tready=1 → output beats appear 1 cycle after each input acceptance, tdata/tkeep/tuser identical, tlast on beat 3, grant_idx=1.
- All 3 ports send continuous 2-beat packets → output packet order 0,1,2,0,1,2; no interleaving; 100% output utilisation after the first cycle.
- Port 0 is mid-packet and drops tvalid for 4 cycles while port 2 is valid → port 2 tready stays 0 and no port-2 beat appears until port 0's tlast is accepted.
- Backpressure: m_tready toggles 1,0,0,1 during a 5-beat packet → no beat lost or duplicated, output held stable while stalled, s_tready drops once 2 beats are buffered.
- Assert user_reset_n=0 on beat 2 of a 4-beat packet → next cycle m_tvalid=0, busy=0, rr_ptr=0. After release, a new packet from port 2 is granted cleanly.
- RQ_ARB_PORT0_PRIORITY_EN: ports 0,1,2 all continuously valid with single-beat packets → port 0 granted every time. Dropping port 0 → ports 1,2 alternate.
